mem_io_arbiter: RTL and testbench

- Shares the data-memory port and the memory-mapped LED/switch IO bus between two requesters: the CPU load/store path and the UART program loader.
- Arbitrates round-robin, sequences each access as a fixed 3-cycle transaction, decodes IO chip-selects, and returns read data with a one-cycle ack.
- Sits between the CPU/loader and the data memory, LED and switch blocks, replacing direct CPU wiring of those blocks.

---
 rtl/mem_io_pkg.sv | 28 ++
 rtl/io_addr_decode.sv | 33 +++
 rtl/mem_io_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_io_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_pkg
//  Purpose  : Shared types and constants for the data-memory / IO arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_io_pkg;

    // Arbiter transaction sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Requester identity, also used as the round-robin history bit
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LD  = 1'b1
    } grant_e;

    // Default IO map: page 0xFFFFFC00-0xFFFFFFFF, LED at 0x60, switches at 0x70
    localparam logic [21:0] c_io_hi    = 22'h3FFFFF;
    localparam logic [9:0]  c_led_base = 10'h060;
    localparam logic [9:0]  c_sw_base  = 10'h070;

endpackage : mem_io_pkg
`default_nettype wire

// File: rtl/io_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : io_addr_decode
//  Purpose  : Combinational classification of a latched access address into
//             memory / LED / switch / unmapped space plus alignment check.
//  Revision : 1.0  initial release
// ============================================================================
module io_addr_decode
    import mem_io_pkg::*;
#(
    parameter logic [21:0] IO_HI    = c_io_hi,
    parameter logic [9:0]  LED_BASE = c_led_base,
    parameter logic [9:0]  SW_BASE  = c_sw_base
) (
    input  logic [31:0] addr,
    output logic        is_io,
    output logic        is_led,
    output logic        is_sw,
    output logic        unmapped,
    output logic        misaligned
);

    // IO blocks are 16-bit wide so only bit 0 must be clear there; memory is word-wide
    always_comb begin
        is_io      = (addr[31:10] == IO_HI);
        is_led     = is_io && (addr[9:2] == LED_BASE[9:2]);
        is_sw      = is_io && (addr[9:2] == SW_BASE[9:2]);
        unmapped   = is_io && !is_led && !is_sw;
        misaligned = is_io ? addr[0] : (addr[1:0] != 2'b00);
    end

endmodule : io_addr_decode
`default_nettype wire

// File: rtl/mem_io_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_arbiter
//  Purpose  : Round-robin arbiter sharing the data memory and LED/switch IO
//             between the CPU and the UART loader; fixed 3-cycle accesses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_io_arbiter
    import mem_io_pkg::*;
#(
    parameter int          MEM_ADDR_W = 14,
    parameter logic [21:0] IO_HI      = c_io_hi,
    parameter logic [9:0]  LED_BASE   = c_led_base,
    parameter logic [9:0]  SW_BASE    = c_sw_base
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  cpu_stall,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [31:0]           ld_addr,
    input  logic [31:0]           ld_wdata,
    output logic                  ld_ack,
    output logic                  ld_err,
    output logic [31:0]           rdata,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  led_cs,
    output logic                  led_we,
    output logic [1:0]            led_addr,
    output logic [15:0]           led_wdata,
    output logic                  sw_cs,
    output logic                  sw_rd,
    output logic [1:0]            sw_addr,
    input  logic [15:0]           sw_rdata
);

    state_e                state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    grant_e                gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;

    grant_e                w_win;
    logic [31:0]           w_win_addr;
    logic                  w_is_io, w_is_led, w_is_sw, w_unmapped, w_misaligned;
    logic                  w_err;

    io_addr_decode #(
        .IO_HI    (IO_HI),
        .LED_BASE (LED_BASE),
        .SW_BASE  (SW_BASE)
    ) u_decode (
        .addr       (addr_q),
        .is_io      (w_is_io),
        .is_led     (w_is_led),
        .is_sw      (w_is_sw),
        .unmapped   (w_unmapped),
        .misaligned (w_misaligned)
    );

    assign w_err = w_unmapped | w_misaligned;

    // Round-robin pick: on a tie the requester not served last time wins
    always_comb begin
        w_win = GNT_CPU;
        if (cpu_req && ld_req) begin
            w_win = (last_grant_q == GNT_CPU) ? GNT_LD : GNT_CPU;
        end else if (ld_req) begin
            w_win = GNT_LD;
        end
        w_win_addr = (w_win == GNT_CPU) ? cpu_addr : ld_addr;
    end

    // Sequencer next state and request latching on the IDLE->ISSUE edge
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || ld_req) begin
                    state_d      = ISSUE;
                    gnt_d        = w_win;
                    last_grant_d = w_win;
                    we_d         = (w_win == GNT_CPU) ? cpu_we    : ld_we;
                    addr_d       = w_win_addr;
                    wdata_d      = (w_win == GNT_CPU) ? cpu_wdata : ld_wdata;
                    // Only memory accesses move the memory address bus
                    if (w_win_addr[31:10] != IO_HI) begin
                        mem_addr_d = w_win_addr[MEM_ADDR_W+1:2];
                    end
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_LD;
            gnt_q        <= GNT_CPU;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Strobes, acks and read-data mux; reset masks everything so an aborted
    // ISSUE never commits a write at the same edge that clears the state
    always_comb begin
        mem_we  = 1'b0;
        led_cs  = 1'b0;
        led_we  = 1'b0;
        sw_cs   = 1'b0;
        sw_rd   = 1'b0;
        cpu_ack = 1'b0;
        ld_ack  = 1'b0;
        cpu_err = 1'b0;
        ld_err  = 1'b0;
        rdata   = 32'h0;
        if (!reset && state_q == ISSUE && !w_err) begin
            if (!w_is_io) begin
                mem_we = we_q;
            end else if (w_is_led) begin
                led_cs = 1'b1;
                led_we = we_q;
            end else if (w_is_sw) begin
                sw_cs = 1'b1;
                sw_rd = ~we_q;
            end
        end
        if (!reset && state_q == RESP) begin
            cpu_ack = (gnt_q == GNT_CPU);
            ld_ack  = (gnt_q == GNT_LD);
            cpu_err = (gnt_q == GNT_CPU) && w_err;
            ld_err  = (gnt_q == GNT_LD) && w_err;
            if (!w_err) begin
                if (!w_is_io) begin
                    rdata = mem_rdata;
                end else if (w_is_sw && !we_q) begin
                    rdata = {16'h0, sw_rdata};
                end
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;
    assign led_addr  = addr_q[1:0];
    assign led_wdata = wdata_q[15:0];
    assign sw_addr   = addr_q[1:0];

endmodule : mem_io_arbiter
`default_nettype wire

// File: tb/tb_mem_io_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_io_arbiter
//  Purpose  : Directed self-checking bench for mem_io_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_io_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ack, cpu_err, cpu_stall;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_ack, ld_err;
    logic [31:0] rdata;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        led_cs, led_we;
    logic [1:0]  led_addr;
    logic [15:0] led_wdata;
    logic        sw_cs, sw_rd;
    logic [1:0]  sw_addr;
    logic [15:0] sw_rdata;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    // Data memory model with synchronous 1-cycle read
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    mem_io_arbiter dut (
        .clock     (clk),
        .reset     (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_ack    (ld_ack),
        .ld_err    (ld_err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .led_cs    (led_cs),
        .led_we    (led_we),
        .led_addr  (led_addr),
        .led_wdata (led_wdata),
        .sw_cs     (sw_cs),
        .sw_rd     (sw_rd),
        .sw_addr   (sw_addr),
        .sw_rdata  (sw_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic reset_pulse;
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0;  ld_we = 0;  ld_addr = 0;  ld_wdata = 0;
        sw_rdata = 16'h0;

        // ---- reset state
        reset_pulse();
        nxt();
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ld_ack", ld_ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_led_cs", led_cs, 0);
        chk("rst_sw_cs", sw_cs, 0);
        chk("rst_stall", cpu_stall, 0);

        // ---- CPU write 0x10 <= DEADBEEF
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1 chk("wr_c0_stall", cpu_stall, 1);
        nxt();
        chk("wr_c1_mem_we", mem_we, 1);
        chk("wr_c1_mem_addr", mem_addr, 4);
        chk("wr_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_c1_stall", cpu_stall, 1);
        chk("wr_c1_ack", cpu_ack, 0);
        nxt();
        chk("wr_c2_ack", cpu_ack, 1);
        chk("wr_c2_err", cpu_err, 0);
        chk("wr_c2_stall", cpu_stall, 0);
        chk("wr_c2_mem_we", mem_we, 0);
        cpu_req = 0;

        // ---- CPU read 0x10
        nxt();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1 chk("rd_c0_ack", cpu_ack, 0);
        nxt();
        chk("rd_c1_mem_we", mem_we, 0);
        chk("rd_c1_mem_addr", mem_addr, 4);
        nxt();
        chk("rd_c2_ack", cpu_ack, 1);
        chk("rd_c2_rdata", rdata, 32'hDEADBEEF);
        cpu_req = 0;

        // ---- tie from reset: CPU first, then loader, then CPU again
        nxt();
        reset_pulse();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        ld_req = 1;  ld_we = 1;  ld_addr = 32'h14; ld_wdata = 32'h000055AA;
        #1 chk("tie_c0_stall", cpu_stall, 1);
        nxt();
        chk("tie_c1_mem_we", mem_we, 0);
        chk("tie_c1_mem_addr", mem_addr, 4);
        nxt();
        chk("tie_c2_cpu_ack", cpu_ack, 1);
        chk("tie_c2_ld_ack", ld_ack, 0);
        chk("tie_c2_rdata", rdata, 32'hDEADBEEF);
        nxt();
        chk("tie_c3_cpu_ack", cpu_ack, 0);
        chk("tie_c3_stall", cpu_stall, 1);
        nxt();
        chk("tie_c4_mem_we", mem_we, 1);
        chk("tie_c4_mem_addr", mem_addr, 5);
        chk("tie_c4_mem_wdata", mem_wdata, 32'h000055AA);
        nxt();
        chk("tie_c5_ld_ack", ld_ack, 1);
        chk("tie_c5_ld_err", ld_err, 0);
        chk("tie_c5_cpu_ack", cpu_ack, 0);
        chk("tie_c5_stall", cpu_stall, 1);
        ld_req = 0;
        nxt();
        chk("tie_c6_ld_ack", ld_ack, 0);
        nxt();
        chk("tie_c7_mem_addr", mem_addr, 4);
        nxt();
        chk("tie_c8_cpu_ack", cpu_ack, 1);
        chk("tie_c8_rdata", rdata, 32'hDEADBEEF);
        cpu_req = 0;

        // ---- LED write 0xFFFFFC62 <= 0xAB
        nxt();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'hFFFFFC62; cpu_wdata = 32'h000000AB;
        nxt();
        chk("led_cs", led_cs, 1);
        chk("led_we", led_we, 1);
        chk("led_addr", led_addr, 2'b10);
        chk("led_wdata", led_wdata, 16'h00AB);
        chk("led_mem_we", mem_we, 0);
        chk("led_mem_addr_held", mem_addr, 4);
        nxt();
        chk("led_ack", cpu_ack, 1);
        chk("led_err", cpu_err, 0);
        chk("led_cs_resp", led_cs, 0);
        cpu_req = 0;

        // ---- switch read 0xFFFFFC70
        nxt();
        sw_rdata = 16'h1234;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFFFC70;
        nxt();
        chk("sw_cs", sw_cs, 1);
        chk("sw_rd", sw_rd, 1);
        chk("sw_addr", sw_addr, 0);
        chk("sw_led_cs", led_cs, 0);
        nxt();
        chk("sw_ack", cpu_ack, 1);
        chk("sw_err", cpu_err, 0);
        chk("sw_rdata", rdata, 32'h00001234);
        cpu_req = 0;

        // ---- misaligned memory write 0x13
        nxt();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h13; cpu_wdata = 32'hFFFFFFFF;
        nxt();
        chk("mis_mem_we", mem_we, 0);
        chk("mis_led_cs", led_cs, 0);
        chk("mis_sw_cs", sw_cs, 0);
        nxt();
        chk("mis_ack", cpu_ack, 1);
        chk("mis_err", cpu_err, 1);
        chk("mis_rdata", rdata, 0);
        cpu_req = 0;

        // ---- unmapped IO read 0xFFFFFC80
        nxt();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFFFC80;
        nxt();
        chk("unm_sw_cs", sw_cs, 0);
        chk("unm_sw_rd", sw_rd, 0);
        chk("unm_led_cs", led_cs, 0);
        chk("unm_mem_we", mem_we, 0);
        nxt();
        chk("unm_ack", cpu_ack, 1);
        chk("unm_err", cpu_err, 1);
        chk("unm_rdata", rdata, 0);
        cpu_req = 0;

        // ---- reset during ISSUE of a loader write aborts it
        nxt();
        ld_req = 1; ld_we = 1; ld_addr = 32'h10; ld_wdata = 32'h11111111;
        nxt();
        rst = 1; ld_req = 0;
        #1 chk("abort_mem_we", mem_we, 0);
        chk("abort_ld_ack_issue", ld_ack, 0);
        nxt();
        chk("abort_ld_ack_resp", ld_ack, 0);
        rst = 0;
        nxt();
        chk("abort_ld_ack_after", ld_ack, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        nxt();
        chk("abort_rb_mem_addr", mem_addr, 4);
        nxt();
        chk("abort_rb_ack", cpu_ack, 1);
        chk("abort_rb_rdata", rdata, 32'hDEADBEEF);
        cpu_req = 0;
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_io_arbiter
`default_nettype wire
